ili9341_spi_master: RTL

- Byte-wide SPI mode-0 master that sits directly downstream of ili9341_spi_controller.
- It consumes the controller's start, byte and data/command strobe, and shifts the byte out on SCK/MOSI to the ILI9341 panel.
- In the same transfer it samples MISO, then returns the captured byte and a busy flag to the controller.
- One 8-bit transfer per start; MSB first; the D/C line is held stable for the whole byte.

---
 rtl/ili9341_spi_master.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ili9341_spi_master.sv
// ili9341_spi_master: byte-wide SPI mode-0 master feeding the ILI9341 panel.
// Define ILI9341_SPI_CS_KEEP_EN to hold cs_n low across back-to-back bytes.
module ili9341_spi_master #(
  parameter int CLK_DIV        = 2,
  parameter int CS_IDLE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       dis_reset,
  input  logic       spi_start,
  input  logic [7:0] spi_out,
  input  logic       dc_in,
  output logic       spi_busy,
  output logic [7:0] spi_in,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n,
  output logic       dc
);

  if (CLK_DIV < 1 || CS_IDLE_CYCLES < 1) begin : g_bad_param
    $error("CLK_DIV and CS_IDLE_CYCLES must be >= 1");
  end

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rx_q, rx_d;
  logic          busy_q, busy_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          cs_q, cs_d;
  logic          dc_q, dc_d;
  logic          div_done;

`ifdef ILI9341_SPI_CS_KEEP_EN
  localparam int IW = $clog2(CS_IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(CS_IDLE_CYCLES - 1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  assign div_done = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    unique case (state_q)
      IDLE: begin
        if (spi_start) begin
          sh_d    = spi_out;
          dc_d    = dc_in;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          mosi_d  = spi_out[7];
          div_d   = '0;
          bit_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_done) begin
          // shifted-out MSB makes room for the sampled MISO bit
          sck_d   = 1'b1;
          sh_d    = {sh_q[6:0], miso};
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_done) begin
          sck_d = 1'b0;
          div_d = '0;
          if (bit_q != 3'd7) begin
            bit_d   = bit_q + 3'd1;
            mosi_d  = sh_q[7];
            state_d = LOW;
          end else begin
            rx_d = sh_q;
`ifdef ILI9341_SPI_CS_KEEP_EN
            busy_d  = 1'b0;
            state_d = IDLE;
`else
            cs_d    = 1'b1;
            state_d = GAP;
`endif
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        if (div_done) begin
          busy_d  = 1'b0;
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ILI9341_SPI_CS_KEEP_EN
  always_comb begin
    idle_d = '0;
    if (state_q == IDLE && !spi_start && !cs_q) begin
      if (idle_q == IDLE_LAST) begin
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge dis_reset) begin
    if (dis_reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge dis_reset) begin
    if (dis_reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      dc_q    <= dc_d;
`ifdef ILI9341_SPI_CS_KEEP_EN
      // frame stays open until the idle window expires
      if (state_q == IDLE && !spi_start && !cs_q
          && idle_q == IDLE_LAST) begin
        cs_q <= 1'b1;
      end else begin
        cs_q <= cs_d;
      end
`else
      cs_q    <= cs_d;
`endif
    end
  end

  assign spi_busy = busy_q;
  assign spi_in   = rx_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_q;
  assign dc       = dc_q;

endmodule
